// File: rtl/csr_pkg.sv
// Shared encodings and sizing helpers for the CSR sparse-matrix x dense-vector engine.
package csr_pkg;

    typedef enum logic [1:0] {
        SEL_VAL = 2'd0,
        SEL_COL = 2'd1,
        SEL_PTR = 2'd2,
        SEL_VEC = 2'd3
    } ld_sel_e;

    typedef enum logic [2:0] {
        StIdle,
        StRowFetch,
        StMac,
        StDrain,
        StEmit,
        StDone
    } state_e;

    // Vector read, multiply and accumulate stages that trail the last issued address.
    localparam int unsigned DRAIN_CYCLES = 3;

    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/csr_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
module csr_dp_ram
    import csr_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR SpMV engine: loads matrix/vector RAMs, then streams one signed dot product per row.
module csr_spmv_engine
    import csr_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ACC_W     = 64,
    parameter int unsigned NNZ_DEPTH = 16384,
    parameter int unsigned ROWS      = 1024,
    parameter int unsigned COLS      = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(ROWS):0]        cfg_rows,
    input  logic                         ld_valid,
    output logic                         ld_ready,
    input  logic [1:0]                   ld_sel,
    input  logic [$clog2(NNZ_DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]            ld_data,
    input  logic                         start,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(ROWS)-1:0]      out_row,
    output logic [ACC_W-1:0]             out_data,
    output logic                         out_zero,
    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    localparam int unsigned RW  = $clog2(ROWS) + 1;
    localparam int unsigned OW  = $clog2(ROWS);
    localparam int unsigned NAW = addr_w(NNZ_DEPTH);
    localparam int unsigned PAW = addr_w(ROWS + 1);
    localparam int unsigned VAW = addr_w(COLS);
    localparam int unsigned PW  = 2 * DATA_W;

    state_e state_q, state_d;

    logic [1:0]        cnt_q;
    logic [RW-1:0]     n_q, r_q;
    logic [DATA_W-1:0] ptr_start_q, mac_addr_q, mac_end_q;
    logic              zero_q, err_q;
    logic [2:0]        pipe_v_q;
    logic [DATA_W-1:0] val_q;
    logic              bad_q;
    logic signed [PW-1:0] prod_q, prod_d;
    logic [ACC_W-1:0]  acc_q;

    logic [DATA_W-1:0] val_rdata, col_rdata, ptr_rdata, vec_rdata;
    logic [PAW-1:0]    ptr_raddr;
    logic              ld_fire, ld_oob;
    logic              we_val, we_col, we_ptr, we_vec;
    logic              ptr_bad, ptr_empty, mac_last, col_oob;

    // Load port address checks and per-RAM write enables.
    assign ld_fire = ld_valid && (state_q == StIdle);

    always_comb begin
        ld_oob = 1'b0;
        unique case (ld_sel_e'(ld_sel))
            SEL_VAL, SEL_COL: ld_oob = 32'(ld_addr) >= NNZ_DEPTH;
            SEL_PTR:          ld_oob = 32'(ld_addr) > ROWS;
            default:          ld_oob = 32'(ld_addr) >= COLS;
        endcase
    end

    assign we_val = ld_fire && !ld_oob && (ld_sel_e'(ld_sel) == SEL_VAL);
    assign we_col = ld_fire && !ld_oob && (ld_sel_e'(ld_sel) == SEL_COL);
    assign we_ptr = ld_fire && !ld_oob && (ld_sel_e'(ld_sel) == SEL_PTR);
    assign we_vec = ld_fire && !ld_oob && (ld_sel_e'(ld_sel) == SEL_VEC);

    // rowptr[r] is requested the cycle before ROW_FETCH so rowptr[r+1] lands in its second cycle.
    assign ptr_raddr = (state_q == StIdle) ? '0 : PAW'(r_q + RW'(1));

    csr_dp_ram #(.DEPTH(NNZ_DEPTH), .WIDTH(DATA_W), .AW(NAW)) u_val_ram (
        .clk   (clk),
        .we    (we_val),
        .waddr (NAW'(ld_addr)),
        .wdata (ld_data),
        .raddr (NAW'(mac_addr_q)),
        .rdata (val_rdata)
    );

    csr_dp_ram #(.DEPTH(NNZ_DEPTH), .WIDTH(DATA_W), .AW(NAW)) u_col_ram (
        .clk   (clk),
        .we    (we_col),
        .waddr (NAW'(ld_addr)),
        .wdata (ld_data),
        .raddr (NAW'(mac_addr_q)),
        .rdata (col_rdata)
    );

    csr_dp_ram #(.DEPTH(ROWS + 1), .WIDTH(DATA_W), .AW(PAW)) u_ptr_ram (
        .clk   (clk),
        .we    (we_ptr),
        .waddr (PAW'(ld_addr)),
        .wdata (ld_data),
        .raddr (ptr_raddr),
        .rdata (ptr_rdata)
    );

    csr_dp_ram #(.DEPTH(COLS), .WIDTH(DATA_W), .AW(VAW)) u_vec_ram (
        .clk   (clk),
        .we    (we_vec),
        .waddr (VAW'(ld_addr)),
        .wdata (ld_data),
        .raddr (VAW'(col_rdata)),
        .rdata (vec_rdata)
    );

    assign ptr_bad   = (ptr_rdata < ptr_start_q) || (ptr_rdata > DATA_W'(NNZ_DEPTH));
    assign ptr_empty = (ptr_rdata == ptr_start_q);
    assign mac_last  = (mac_addr_q + DATA_W'(1)) == mac_end_q;
    assign col_oob   = col_rdata >= DATA_W'(COLS);
    assign prod_d    = PW'($signed(val_q)) * PW'($signed(vec_rdata));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start) state_d = (cfg_rows == '0) ? StDone : StRowFetch;
            StRowFetch: if (cnt_q != 2'd0) state_d = (ptr_bad || ptr_empty) ? StEmit : StMac;
            StMac:      if (mac_last) state_d = StDrain;
            StDrain:    if (cnt_q == 2'(DRAIN_CYCLES - 1)) state_d = StEmit;
            StEmit:     if (out_ready) state_d = (r_q + RW'(1) == n_q) ? StDone : StRowFetch;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        ld_ready  = (state_q == StIdle);
        busy      = (state_q != StIdle);
        done      = (state_q == StDone);
        out_valid = (state_q == StEmit);
        out_row   = out_valid ? r_q[OW-1:0] : '0;
        out_zero  = out_valid && zero_q;
        out_data  = (out_valid && !zero_q) ? acc_q : '0;
        err       = err_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q       <= '0;
            n_q         <= '0;
            r_q         <= '0;
            ptr_start_q <= '0;
            mac_addr_q  <= '0;
            mac_end_q   <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            pipe_v_q    <= '0;
            val_q       <= '0;
            bad_q       <= 1'b0;
            prod_q      <= '0;
            acc_q       <= '0;
        end else begin
            // Stage 1: val/col data back; stage 2: vector data, multiply; stage 3: accumulate.
            pipe_v_q <= {pipe_v_q[1:0], state_q == StMac};
            if (pipe_v_q[0]) begin
                val_q <= val_rdata;
                bad_q <= col_oob;
            end
            if (pipe_v_q[1]) prod_q <= bad_q ? '0 : prod_d;
            if (pipe_v_q[2]) acc_q <= acc_q + ACC_W'(prod_q);

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        n_q   <= cfg_rows;
                        r_q   <= '0;
                        err_q <= 1'b0;
                    end
                end
                StRowFetch: begin
                    if (cnt_q == 2'd0) begin
                        ptr_start_q <= ptr_rdata;
                        acc_q       <= '0;
                        cnt_q       <= 2'd1;
                    end else begin
                        cnt_q      <= 2'd0;
                        mac_addr_q <= ptr_start_q;
                        mac_end_q  <= ptr_rdata;
                        zero_q     <= ptr_bad || ptr_empty;
                        if (ptr_bad) err_q <= 1'b1;
                    end
                end
                StMac:   mac_addr_q <= mac_addr_q + DATA_W'(1);
                StDrain: cnt_q <= (cnt_q == 2'(DRAIN_CYCLES - 1)) ? 2'd0 : cnt_q + 2'd1;
                StEmit:  if (out_ready) r_q <= r_q + RW'(1);
                default: ;
            endcase

            if (pipe_v_q[0] && col_oob) err_q <= 1'b1;
            if (ld_fire && ld_oob) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Scoreboard bench for csr_spmv_engine: directed golden cases plus randomized CSR matrices.
module tb_csr_spmv_engine;

    localparam int DW   = 32;
    localparam int AW   = 64;
    localparam int NNZ  = 48;
    localparam int ROWS = 12;
    localparam int COLS = 20;
    localparam int LAW  = $clog2(NNZ);
    localparam int RW   = $clog2(ROWS) + 1;
    localparam int OW   = $clog2(ROWS);

    typedef struct {
        int          row;
        logic [63:0] data;
        bit          zero;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [RW-1:0]   cfg_rows = '0;
    logic            ld_valid = 1'b0;
    logic            ld_ready;
    logic [1:0]      ld_sel = '0;
    logic [LAW-1:0]  ld_addr = '0;
    logic [DW-1:0]   ld_data = '0;
    logic            start = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [OW-1:0]   out_row;
    logic [AW-1:0]   out_data;
    logic            out_zero, busy, done, err;

    logic [31:0] m_val [NNZ];
    logic [31:0] m_col [NNZ];
    logic [31:0] m_ptr [ROWS + 1];
    logic [31:0] m_vec [COLS];

    exp_t         exp_q[$];
    exp_t         mon_e;
    int           total = 0;
    int           bad = 0;
    int           done_cnt = 0;
    int           rdy_mode = 0;
    bit           run_err;
    bit           held = 0;
    logic [127:0] held_val;

    csr_spmv_engine #(
        .DATA_W(DW), .ACC_W(AW), .NNZ_DEPTH(NNZ), .ROWS(ROWS), .COLS(COLS)
    ) dut (
        .clk(clk), .reset(reset), .cfg_rows(cfg_rows),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel), .ld_addr(ld_addr),
        .ld_data(ld_data), .start(start),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_data(out_data), .out_zero(out_zero),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Sink backpressure: 0 = always ready, 1 = random, 2 = driven by the stimulus thread.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            held = 0;
        end else begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (held) check("hold_stable", {out_row, out_data, out_zero}, held_val);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_output: row %0d data %0h, none expected",
                                 out_row, out_data);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("row_result", {out_row, out_data, out_zero},
                              {mon_e.row[OW-1:0], mon_e.data, mon_e.zero});
                    end
                    held = 0;
                end else begin
                    held = 1;
                    held_val = {out_row, out_data, out_zero};
                end
            end else begin
                held = 0;
            end
        end
    end

    task automatic load(input int sel, input int addr, input logic [31:0] data);
        ld_valid = 1'b1;
        ld_sel   = sel[1:0];
        ld_addr  = addr[LAW-1:0];
        ld_data  = data;
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        case (sel)
            0: if (addr < NNZ) m_val[addr] = data;
            1: if (addr < NNZ) m_col[addr] = data;
            2: if (addr <= ROWS) m_ptr[addr] = data;
            default: if (addr < COLS) m_vec[addr] = data;
        endcase
    endtask

    // Reference: per-row CSR dot product straight from the loaded arrays.
    task automatic start_run(input int n);
        int unsigned s, e, c;
        longint      acc;
        bit          z;
        int          lat;
        int          want_lat;
        want_lat = 0;
        run_err  = 0;
        for (int r = 0; r < n; r++) begin
            s   = m_ptr[r];
            e   = m_ptr[r + 1];
            acc = 0;
            z   = 0;
            if (e < s || e > NNZ) begin
                run_err = 1;
                z = 1;
            end else if (e == s) begin
                z = 1;
            end else begin
                for (int unsigned j = s; j < e; j++) begin
                    c = m_col[j];
                    if (c >= COLS) run_err = 1;
                    else acc += longint'($signed(m_val[j])) * longint'($signed(m_vec[c]));
                end
            end
            if (r == 0) want_lat = z ? 2 : int'(e - s) + 5;
            exp_q.push_back('{r, acc, z});
        end
        cfg_rows = n[RW-1:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!out_valid && !done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (n == 0) check("zero_rows_done", done, 1);
        else check("first_latency", lat, want_lat);
    endtask

    task automatic finish_run(input int d0);
        int cyc;
        cyc = 0;
        while (busy && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_timeout", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_cnt - d0, 1);
        check("err_flag", err, run_err);
        exp_q.delete();
    endtask

    task automatic run(input int n);
        int d0;
        d0 = done_cnt;
        start_run(n);
        finish_run(d0);
    endtask

    task automatic load_3x3();
        load(0, 0, 1); load(0, 1, 2); load(0, 2, 3);
        load(1, 0, 0); load(1, 1, 2); load(1, 2, 1);
        load(2, 0, 0); load(2, 1, 2); load(2, 2, 2); load(2, 3, 3);
        load(3, 0, 4); load(3, 1, 5); load(3, 2, 6);
    endtask

    initial begin
        int d0, cyc, p, v;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {ld_ready, busy, out_valid, done, err, out_zero, out_row, out_data},
              {1'b1, 5'b0, {OW{1'b0}}, 64'b0});
        reset = 1'b1;
        @(posedge clk);
        #1;

        // 3x3 golden matrix.
        load_3x3();
        run(3);

        // Signed extremes.
        load(0, 0, 32'hFFFF_FFF9); load(0, 1, 32'h7FFF_FFFF);
        load(1, 0, 0); load(1, 1, 0);
        load(2, 0, 0); load(2, 1, 1); load(2, 2, 2);
        load(3, 0, 32'hFFFF_FFFD);
        run(2);

        // Row 0 held under backpressure for 10 cycles.
        load_3x3();
        rdy_mode = 2;
        out_ready = 1'b0;
        d0 = done_cnt;
        start_run(3);
        repeat (10) @(posedge clk);
        #1;
        out_ready = 1'b1;
        rdy_mode = 0;
        finish_run(d0);

        // Decreasing row pointers.
        for (int a = 0; a < 5; a++) begin
            load(0, a, a + 1);
            load(1, a, a);
        end
        load(2, 0, 0); load(2, 1, 5); load(2, 2, 3);
        run(2);

        // Empty matrix, then out-of-range loads.
        run(0);
        load(0, NNZ, 32'h1234);
        check("val_oob_err", err, 1);
        run(0);
        load(3, COLS, 32'h55);
        check("vec_oob_err", err, 1);

        // Reset in the middle of row 1's MAC phase, then a clean rerun.
        for (int a = 0; a < 11; a++) begin
            load(0, a, $urandom);
            load(1, a, a % COLS);
        end
        for (int a = 0; a < COLS; a++) load(3, a, $urandom);
        load(2, 0, 0); load(2, 1, 1); load(2, 2, 11);
        d0 = done_cnt;
        start_run(2);
        cyc = 0;
        while (exp_q.size() != 1 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("reset_setup", exp_q.size(), 1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midrun_reset", {ld_ready, busy, out_valid, done, err, out_row, out_data},
              {1'b1, 4'b0, {OW{1'b0}}, 64'b0});
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_no_done", done_cnt - d0, 0);
        run(2);

        // Randomized matrices with occasional bad pointers and columns.
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < NNZ; a++) begin
                load(0, a, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) - 10 : $urandom);
                load(1, a, ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, COLS - 1));
            end
            p = $urandom_range(0, 3);
            for (int a = 0; a <= ROWS; a++) begin
                v = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 60) : p;
                load(2, a, v);
                p = (p + $urandom_range(0, 5) > NNZ) ? NNZ : p + $urandom_range(0, 5);
            end
            for (int a = 0; a < COLS; a++) load(3, a, $urandom);
            rdy_mode = 1;
            run($urandom_range(1, ROWS));
            rdy_mode = 0;
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
